// File: rtl/serv_bufreg_par.sv
// serv_bufreg_par: W-bit-per-beat buffer register for the bit-serial core.
// Accumulates rs1+imm into a 32-bit dbus address, presents it to the bus, and drains it LSB-first.
module serv_bufreg_par #(
  parameter int W   = 1,
  parameter bit MDU = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_init,
  input  logic         i_rs1_en,
  input  logic         i_imm_en,
  input  logic         i_clr_lsb,
  input  logic         i_sh_signed,
  input  logic         i_mdu_op,
  input  logic [1:0]   i_size,
  input  logic [W-1:0] i_rs1,
  input  logic [W-1:0] i_imm,
  input  logic         i_adr_ack,
  output logic [W-1:0] o_q,
  output logic         o_adr_vld,
  output logic         o_misalign,
  output logic [1:0]   o_lsb,
  output logic [31:0]  o_dbus_adr,
  output logic [31:0]  o_ext_rs1,
  output logic [1:0]   o_dbg_state
);
  localparam int N  = 32 / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_VALID = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_c;
  logic [31:0]   r_data;
  logic          r_misalign;

  logic          w_init_beat;
  logic          w_in_load;
  logic          w_drain_beat;
  logic          w_first;
  logic          w_last;
  logic          w_cin;
  logic          w_mis_nxt;
  logic [CW-1:0] w_cnt_eff;
  logic [W-1:0]  w_imm_m;
  logic [W:0]    w_sum;
  logic [31:0]   w_load_data;
  logic [31:0]   w_drain_data;

  assign w_init_beat  = i_en & i_init;
  assign w_in_load    = (r_state == S_LOAD);
  assign w_drain_beat = i_en & ~i_init & ~w_in_load;

  // An accumulate beat arriving outside LOAD restarts the pass at beat 0 with no carry.
  assign w_cnt_eff = w_in_load ? r_cnt : '0;
  assign w_cin     = w_in_load & r_c;
  assign w_first   = (w_cnt_eff == '0);
  assign w_last    = w_in_load & (r_cnt == CW'(N - 1));

  always_comb begin
    w_imm_m    = i_imm;
    w_imm_m[0] = i_imm[0] & ~(w_first & i_clr_lsb);
  end

  assign w_sum = {1'b0, i_rs1 & {W{i_rs1_en}}}
               + {1'b0, w_imm_m & {W{i_imm_en}}}
               + {{W{1'b0}}, w_cin};

  assign w_load_data  = {w_sum[W-1:0], r_data[31:W]};
  assign w_drain_data = {{W{r_data[31] & i_sh_signed}}, r_data[31:W]};

  always_comb begin
    case (i_size)
      2'b01:   w_mis_nxt = w_load_data[0];
      2'b10:   w_mis_nxt = |w_load_data[1:0];
      default: w_mis_nxt = 1'b0;
    endcase
  end

  // Address handshake: o_adr_vld rises the cycle after the last accumulate beat and holds a
  // stable address until i_adr_ack, a drain beat or a restart; transfer happens on vld & ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_c        <= 1'b0;
      r_data     <= '0;
      r_misalign <= 1'b0;
    end else if (w_init_beat) begin
      r_data <= w_load_data;
      if (w_last) begin
        r_state    <= S_VALID;
        r_cnt      <= '0;
        r_c        <= 1'b0;
        r_misalign <= w_mis_nxt;
      end else begin
        r_state <= S_LOAD;
        r_cnt   <= w_cnt_eff + CW'(1);
        r_c     <= w_sum[W];
      end
    end else if (w_in_load) begin
      if (i_en) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_c     <= 1'b0;
      end
    end else if (w_drain_beat) begin
      r_data <= w_drain_data;
      if ((r_state == S_DRAIN) && (r_cnt == CW'(N - 1))) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= S_DRAIN;
        r_cnt   <= r_cnt + CW'(1);
      end
    end else if ((r_state == S_VALID) && i_adr_ack) begin
      r_state <= S_IDLE;
    end
  end

  assign o_q         = w_drain_beat ? r_data[W-1:0] : '0;
  assign o_adr_vld   = (r_state == S_VALID);
  assign o_misalign  = r_misalign & o_adr_vld;
  assign o_lsb       = (MDU && i_mdu_op) ? 2'b00 : r_data[1:0];
  assign o_dbus_adr  = {r_data[31:2], 2'b00};
  assign o_ext_rs1   = r_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serv_bufreg_par.sv
// Bench for serv_bufreg_par (W=4, MDU=1): directed vectors plus randomized passes,
// with a queue-based scoreboard fed by the drivers and drained by a negedge monitor.
module tb_serv_bufreg_par;
  localparam int W = 4;
  localparam int N = 32 / W;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0, init = 1'b0, rs1_en = 1'b0, imm_en = 1'b0;
  logic         clr_lsb = 1'b0, sh_signed = 1'b0, mdu_op = 1'b0, adr_ack = 1'b0;
  logic [1:0]   size = 2'b00;
  logic [W-1:0] rs1 = '0, imm = '0;
  logic [W-1:0] o_q;
  logic         o_adr_vld, o_misalign;
  logic [1:0]   o_lsb, o_dbg_state;
  logic [31:0]  o_dbus_adr, o_ext_rs1;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [32:0]  adr_q[$];
  logic [W-1:0] exp_q[$];
  logic [31:0]  model_data = '0;
  logic         drv_drain = 1'b0;

  serv_bufreg_par #(.W(W), .MDU(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init), .i_rs1_en(rs1_en),
    .i_imm_en(imm_en), .i_clr_lsb(clr_lsb), .i_sh_signed(sh_signed), .i_mdu_op(mdu_op),
    .i_size(size), .i_rs1(rs1), .i_imm(imm), .i_adr_ack(adr_ack), .o_q(o_q),
    .o_adr_vld(o_adr_vld), .o_misalign(o_misalign), .o_lsb(o_lsb),
    .o_dbus_adr(o_dbus_adr), .o_ext_rs1(o_ext_rs1), .o_dbg_state(o_dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [31:0] b,
                                              input logic ae, input logic be, input logic clr);
    logic [31:0] bm;
    bm = clr ? (b & 32'hFFFF_FFFE) : b;
    return (ae ? a : 32'h0) + (be ? bm : 32'h0);
  endfunction

  function automatic logic model_mis(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b01) return a[0];
    if (sz == 2'b10) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  // monitor
  logic        vld_d = 1'b0;
  logic [32:0] cur = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      vld_d = 1'b0;
    end else begin
      if (o_adr_vld) begin
        if (!vld_d) begin
          if (adr_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL adr_unexpected: got 0x%0h expected no address", o_ext_rs1);
          end else cur = adr_q.pop_front();
        end
        check("dbus_adr", o_dbus_adr, {cur[31:2], 2'b00});
        check("ext_rs1", o_ext_rs1, cur[31:0]);
        check("misalign", o_misalign, cur[32]);
        check("lsb", o_lsb, mdu_op ? 2'b00 : cur[1:0]);
      end else begin
        check("misalign_idle", o_misalign, 1'b0);
      end
      vld_d = o_adr_vld;
      if (drv_drain) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL q_unexpected: got 0x%0h expected no drain beat", o_q);
        end else check("q", o_q, exp_q.pop_front());
      end else begin
        check("q_idle", o_q, '0);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; init = 1'b0; adr_ack = 1'b0; drv_drain = 1'b0;
  endtask

  task automatic load_pass(input logic [31:0] a, input logic [31:0] b, input logic ae,
                           input logic be, input logic clr, input logic [1:0] sz,
                           input int gmin, input int gmax);
    logic [31:0] adr;
    adr = model_addr(a, b, ae, be, clr);
    adr_q.push_back({model_mis(adr, sz), adr});
    model_data = adr;
    size = sz; rs1_en = ae; imm_en = be; clr_lsb = clr;
    for (int k = 0; k < N; k++) begin
      en = 1'b1; init = 1'b1;
      rs1 = a[k*W +: W]; imm = b[k*W +: W];
      tick();
      en = 1'b0; init = 1'b0;
      check("vld_latency", o_adr_vld, k == N - 1);
      check("load_state", o_dbg_state, (k == N - 1) ? ST_VALID : ST_LOAD);
      if (k != N - 1) repeat ($urandom_range(gmax, gmin)) tick();
    end
  endtask

  task automatic partial_load(input int nb, input logic [31:0] a);
    rs1_en = 1'b1; imm_en = 1'b0; clr_lsb = 1'b0;
    for (int k = 0; k < nb; k++) begin
      en = 1'b1; init = 1'b1; rs1 = a[k*W +: W]; imm = '0;
      tick();
    end
  endtask

  task automatic drain(input int nb, input logic sgn, input logic ack_first,
                       input int gmin, input int gmax);
    longint v;
    v = sgn ? longint'($signed(model_data)) : longint'({32'h0, model_data});
    for (int k = 0; k < nb; k++) exp_q.push_back(W'(v >>> (k * W)));
    sh_signed = sgn;
    for (int k = 0; k < nb; k++) begin
      en = 1'b1; init = 1'b0; adr_ack = ack_first && (k == 0); drv_drain = 1'b1;
      tick();
      idle_inputs();
      if (k != nb - 1) repeat ($urandom_range(gmax, gmin)) tick();
    end
    model_data = 32'(v >>> (nb * W));
    check("drain_state", o_dbg_state, (nb == N) ? ST_IDLE : ST_DRAIN);
    check("drain_data", o_ext_rs1, model_data);
    check("drain_lsb", o_lsb, mdu_op ? 2'b00 : model_data[1:0]);
  endtask

  task automatic ack_only();
    adr_ack = 1'b1;
    tick();
    adr_ack = 1'b0;
    check("ack_state", o_dbg_state, ST_IDLE);
    check("ack_vld", o_adr_vld, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_q"}, o_q, '0);
    check({tag, "_vld"}, o_adr_vld, 1'b0);
    check({tag, "_mis"}, o_misalign, 1'b0);
    check({tag, "_lsb"}, o_lsb, 2'b00);
    check({tag, "_adr"}, o_dbus_adr, 32'h0);
    check({tag, "_ext"}, o_ext_rs1, 32'h0);
    check({tag, "_state"}, o_dbg_state, ST_IDLE);
  endtask

  // stimulus
  initial begin
    logic [31:0] ra, rb;
    logic        ae, be, cl, sg;
    logic [1:0]  sz;
    int          choice, nb;

    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    load_pass(32'h0000_1000, 32'h0000_07FF, 1, 1, 0, 2'b10, 0, 0);
    repeat (2) tick();
    ack_only();
    mdu_op = 1'b1;
    load_pass(32'h0000_1000, 32'h0000_07FF, 1, 1, 0, 2'b10, 0, 0);
    ack_only();
    mdu_op = 1'b0;

    load_pass(32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 0, 2'b10, 1, 1);
    ack_only();
    load_pass(32'h0000_0002, 32'h0000_0003, 1, 1, 0, 2'b10, 1, 1);
    ack_only();

    load_pass(32'h0000_0100, 32'h0000_0003, 1, 1, 1, 2'b00, 0, 0);
    ack_only();
    load_pass(32'h0000_0100, 32'h0000_0003, 1, 1, 0, 2'b00, 0, 0);
    ack_only();

    load_pass(32'h8000_0000, 32'h0000_0000, 1, 1, 0, 2'b10, 0, 0);
    drain(N, 1'b1, 1'b1, 0, 0);

    drain(3, 1'b0, 1'b0, 0, 1);
    load_pass(32'h0000_0010, 32'h0000_0007, 1, 1, 1, 2'b01, 0, 0);
    ack_only();

    partial_load(3, 32'hDEAD_BEEF);
    en = 1'b1; init = 1'b0;
    tick();
    idle_inputs();
    check("abort_state", o_dbg_state, ST_IDLE);
    load_pass(32'h1234_5678, 32'h0000_0001, 1, 1, 0, 2'b01, 0, 1);
    drain(N, 1'b0, 1'b0, 0, 1);

    partial_load(4, 32'hFFFF_FFFF);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    idle_inputs();
    tick();
    rst_n = 1'b1;
    model_data = '0;
    tick();
    load_pass(32'h0000_0005, 32'h0000_0003, 1, 1, 0, 2'b10, 0, 0);
    ack_only();

    for (int it = 0; it < 40; it++) begin
      ra = $urandom; rb = $urandom;
      ae = 1'($urandom_range(3, 0) != 0); be = 1'($urandom_range(3, 0) != 0);
      cl = 1'($urandom_range(1, 0)); sz = 2'($urandom_range(3, 0));
      mdu_op = 1'($urandom_range(1, 0));
      load_pass(ra, rb, ae, be, cl, sz, 0, 2);
      repeat ($urandom_range(2, 0)) tick();
      choice = $urandom_range(2, 0);
      nb = $urandom_range(N, 1);
      sg = 1'($urandom_range(1, 0));
      if (choice == 0) begin
        ack_only();
        if ($urandom_range(1, 0) == 1) drain(nb, sg, 1'b0, 0, 2);
      end else begin
        drain(nb, sg, choice == 1, 0, 2);
      end
    end
    mdu_op = 1'b0;
    repeat (2) tick();

    check("adr_q_empty", adr_q.size(), 0);
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
